// File: rtl/flush_bus_if.sv
// Request/broadcast bundle between the flush requesters, the flushed sinks and flush_bus.
// master drives requests and sink acks; slave is the arbiter itself.
interface flush_bus_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int NUM_SRCS      = 2,
    parameter int SRC_IDX_WIDTH = 1,
    parameter int NUM_SINKS     = 5
);
    logic [NUM_SRCS-1:0]            req_valid;
    logic [NUM_SRCS*ADDR_WIDTH-1:0] req_pc;
    logic [NUM_SRCS-1:0]            grant;
    logic                           busy;
    logic [NUM_SINKS-1:0]           flush_out;
    logic                           redirect_valid;
    logic [ADDR_WIDTH-1:0]          redirect_pc;
    logic [SRC_IDX_WIDTH-1:0]       flush_src;
    logic [NUM_SINKS-1:0]           ack_in;
    logic                           timeout_err;
    logic [15:0]                    flush_count;

    modport master (
        output req_valid, req_pc, ack_in,
        input  grant, busy, flush_out, redirect_valid, redirect_pc,
               flush_src, timeout_err, flush_count
    );

    modport slave (
        input  req_valid, req_pc, ack_in,
        output grant, busy, flush_out, redirect_valid, redirect_pc,
               flush_src, timeout_err, flush_count
    );
endinterface

// File: rtl/flush_bus.sv
// Priority flush/redirect arbiter: broadcasts a one-cycle flush pulse to all sinks,
// then holds busy until every required sink has acked or the ack wait times out.
module flush_bus #(
    parameter int                   ADDR_WIDTH    = 32,
    parameter int                   NUM_SRCS      = 2,
    parameter int                   SRC_IDX_WIDTH = 1,
    parameter int                   NUM_SINKS     = 5,
    parameter logic [NUM_SINKS-1:0] ACK_MASK      = {NUM_SINKS{1'b1}},
    parameter int                   TIMEOUT       = 64
) (
    input logic        clk,
    input logic        rst,
    input logic        rdy,
    flush_bus_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BROADCAST,
        WAIT_ACK
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_SRCS-1:0]      grant_q, grant_d;
    logic                     busy_q, busy_d;
    logic [NUM_SINKS-1:0]     flush_q, flush_d;
    logic                     rv_q, rv_d;
    logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
    logic [SRC_IDX_WIDTH-1:0] src_q, src_d;
    logic                     terr_q, terr_d;
    logic [15:0]              count_q, count_d;
    logic [NUM_SINKS-1:0]     mask_q, mask_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic                     win_valid;
    logic [SRC_IDX_WIDTH-1:0] win_idx;
    logic [NUM_SRCS-1:0]      win_onehot;
    logic [ADDR_WIDTH-1:0]    win_pc;
    logic                     mask_full;

    // Descending scan so the lowest requesting index is the last one written.
    always_comb begin
        win_valid  = |bus.req_valid;
        win_idx    = '0;
        win_onehot = '0;
        win_pc     = '0;
        for (int i = NUM_SRCS - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                win_idx       = SRC_IDX_WIDTH'(i);
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
                win_pc        = bus.req_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign mask_full = &(mask_q | bus.ack_in | ~ACK_MASK);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        flush_d = flush_q;
        rv_d    = rv_q;
        pc_d    = pc_q;
        src_d   = src_q;
        terr_d  = terr_q;
        count_d = count_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;

        // Source 0 (ROB) pre-empts an in-flight flush; others are only heard in IDLE.
        if ((state_q == IDLE && win_valid) || (state_q != IDLE && bus.req_valid[0])) begin
            state_d = BROADCAST;
            grant_d = win_onehot;
            busy_d  = 1'b1;
            flush_d = '1;
            rv_d    = 1'b1;
            pc_d    = win_pc;
            src_d   = win_idx;
            count_d = count_q + 16'd1;
            mask_d  = '0;
            cnt_d   = '0;
        end else if (state_q != IDLE) begin
            grant_d = '0;
            flush_d = '0;
            rv_d    = 1'b0;
            mask_d  = mask_q | bus.ack_in;
            if (state_q == WAIT_ACK) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (mask_full) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end else if (state_q == WAIT_ACK && cnt_q == CNT_W'(TIMEOUT - 1)) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                terr_d  = 1'b1;
            end else begin
                state_d = WAIT_ACK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            flush_q <= '0;
            rv_q    <= 1'b0;
            pc_q    <= '0;
            src_q   <= '0;
            terr_q  <= 1'b0;
            count_q <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            flush_q <= flush_d;
            rv_q    <= rv_d;
            pc_q    <= pc_d;
            src_q   <= src_d;
            terr_q  <= terr_d;
            count_q <= count_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant          = grant_q;
    assign bus.busy           = busy_q;
    assign bus.flush_out      = flush_q;
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = pc_q;
    assign bus.flush_src      = src_q;
    assign bus.timeout_err    = terr_q;
    assign bus.flush_count    = count_q;
endmodule

// File: tb/tb_flush_bus.sv
// Self-checking bench for flush_bus: directed scenarios plus randomized traffic,
// scored against a transaction-level reference model through expectation queues.
module tb_flush_bus;
    localparam int             AW    = 32;
    localparam int             NS    = 2;
    localparam int             SW    = 1;
    localparam int             NK    = 5;
    localparam int             TO    = 64;
    localparam logic [NK-1:0]  AMASK = 5'b11111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;

    flush_bus_if #(.ADDR_WIDTH(AW), .NUM_SRCS(NS), .SRC_IDX_WIDTH(SW), .NUM_SINKS(NK)) bus_if ();

    flush_bus #(
        .ADDR_WIDTH(AW), .NUM_SRCS(NS), .SRC_IDX_WIDTH(SW), .NUM_SINKS(NK),
        .ACK_MASK(AMASK), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [NS-1:0] grant;
        logic [AW-1:0] pc;
        logic [SW-1:0] src;
        logic [15:0]   count;
    } flush_exp_t;

    flush_exp_t flush_q[$];
    bit         end_q[$];

    // Reference model: a flush is a transaction aged in edges since acceptance;
    // it ends when every required sink has acked, or times out TO+1 edges after acceptance.
    bit            m_busy, m_pulse, m_terr, m_was_reset;
    int            m_age, m_count, m_src;
    logic [NK-1:0] m_got;
    logic [AW-1:0] m_pc;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rd, input logic [NS-1:0] req,
                                 input logic [AW-1:0] pc0, input logic [AW-1:0] pc1,
                                 input logic [NK-1:0] ack);
        rst              = r;
        rdy              = rd;
        bus_if.req_valid = req;
        bus_if.req_pc    = {pc1, pc0};
        bus_if.ack_in    = ack;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin : model
        int         win;
        flush_exp_t e;
        m_was_reset = 1'b0;
        if (rst) begin
            m_busy = 0; m_pulse = 0; m_terr = 0; m_count = 0; m_got = '0; m_age = 0;
            m_pc = '0; m_src = 0; m_was_reset = 1'b1;
        end else if (rdy) begin
            win = -1;
            if (!m_busy) begin
                for (int i = NS - 1; i >= 0; i--) if (bus_if.req_valid[i]) win = i;
            end else if (bus_if.req_valid[0]) begin
                win = 0;
            end
            m_pulse = 0;
            if (win >= 0) begin
                m_count = (m_count + 1) % 65536;
                m_busy = 1; m_pulse = 1; m_got = '0; m_age = 0;
                m_pc = bus_if.req_pc[win*AW +: AW];
                m_src = win;
                e.grant = NS'(1) << win;
                e.pc    = m_pc;
                e.src   = SW'(win);
                e.count = 16'(m_count);
                flush_q.push_back(e);
            end else if (m_busy) begin
                m_age++;
                m_got = m_got | (bus_if.ack_in & AMASK);
                if (m_got == AMASK) begin
                    m_busy = 0;
                    end_q.push_back(m_terr);
                end else if (m_age == TO + 1) begin
                    m_terr = 1;
                    m_busy = 0;
                    end_q.push_back(m_terr);
                end
            end
        end
    end

    // Monitor: per-cycle level checks, plus queue pops on each new flush and each busy fall.
    initial begin : monitor
        logic [15:0] last_count;
        logic        last_busy;
        flush_exp_t  e;
        bit          t;
        last_count = '0;
        last_busy  = 1'b0;
        forever begin
            @(negedge clk);
            checkOutput("busy", bus_if.busy, m_busy);
            checkOutput("flush_out", bus_if.flush_out, m_pulse ? 64'h1f : 64'h0);
            checkOutput("redirect_valid", bus_if.redirect_valid, m_pulse);
            checkOutput("timeout_err", bus_if.timeout_err, m_terr);
            if (!m_pulse) checkOutput("grant_idle", bus_if.grant, 0);
            if (!m_was_reset && bus_if.flush_count !== last_count) begin
                if (flush_q.size() == 0) begin
                    checkOutput("flush_unexpected", bus_if.flush_count, last_count);
                end else begin
                    e = flush_q.pop_front();
                    checkOutput("flush_grant", bus_if.grant, e.grant);
                    checkOutput("flush_pc", bus_if.redirect_pc, e.pc);
                    checkOutput("flush_src", bus_if.flush_src, e.src);
                    checkOutput("flush_count", bus_if.flush_count, e.count);
                end
            end
            if (!m_was_reset && last_busy && !bus_if.busy) begin
                if (end_q.size() == 0) begin
                    checkOutput("end_unexpected", bus_if.busy, 1);
                end else begin
                    t = end_q.pop_front();
                    checkOutput("end_timeout_err", bus_if.timeout_err, t);
                    checkOutput("end_pc_hold", bus_if.redirect_pc, m_pc);
                    checkOutput("end_src_hold", bus_if.flush_src, m_src);
                end
            end
            last_count = bus_if.flush_count;
            last_busy  = bus_if.busy;
        end
    end

    initial begin : stimulus
        logic [NS-1:0] req;
        logic [NK-1:0] ack;
        bit            dead;

        applyStimulus(1, 1, 2'b00, 0, 0, 0);
        applyStimulus(1, 1, 2'b00, 0, 0, 0);
        checkOutput("reset_busy", bus_if.busy, 0);
        checkOutput("reset_count", bus_if.flush_count, 0);

        // Single source-1 flush, acked in the broadcast cycle.
        applyStimulus(0, 1, 2'b10, 0, 32'h1000, 0);
        checkOutput("t1_flush_out", bus_if.flush_out, 5'b11111);
        checkOutput("t1_pc", bus_if.redirect_pc, 32'h1000);
        checkOutput("t1_grant", bus_if.grant, 2'b10);
        checkOutput("t1_src", bus_if.flush_src, 1);
        checkOutput("t1_busy", bus_if.busy, 1);
        applyStimulus(0, 1, 2'b00, 0, 0, 5'b11111);
        checkOutput("t1_busy_end", bus_if.busy, 0);
        checkOutput("t1_count", bus_if.flush_count, 1);

        // Simultaneous requests: source 0 wins.
        applyStimulus(0, 1, 2'b11, 32'h200, 32'h300, 0);
        checkOutput("t2_grant", bus_if.grant, 2'b01);
        checkOutput("t2_pc", bus_if.redirect_pc, 32'h200);
        applyStimulus(0, 1, 2'b00, 0, 0, 5'b11111);
        checkOutput("t2_busy_end", bus_if.busy, 0);

        // Pre-emption in WAIT_ACK discards already captured acks.
        applyStimulus(0, 1, 2'b01, 32'h100, 0, 0);
        applyStimulus(0, 1, 2'b00, 0, 0, 5'b00011);
        applyStimulus(0, 1, 2'b00, 0, 0, 0);
        applyStimulus(0, 1, 2'b01, 32'h400, 0, 0);
        checkOutput("t3_flush_out", bus_if.flush_out, 5'b11111);
        checkOutput("t3_pc", bus_if.redirect_pc, 32'h400);
        applyStimulus(0, 1, 2'b00, 0, 0, 5'b11100);
        checkOutput("t3_still_busy", bus_if.busy, 1);
        applyStimulus(0, 1, 2'b00, 0, 0, 5'b00011);
        checkOutput("t3_busy_end", bus_if.busy, 0);
        checkOutput("t3_count", bus_if.flush_count, 4);

        // Sink 3 never acks: timeout, then sticky error across a good flush.
        applyStimulus(0, 1, 2'b01, 32'h500, 0, 0);
        for (int i = 0; i < 70; i++) applyStimulus(0, 1, 2'b00, 0, 0, 5'b10111);
        checkOutput("t4_terr", bus_if.timeout_err, 1);
        checkOutput("t4_busy", bus_if.busy, 0);
        applyStimulus(0, 1, 2'b10, 0, 32'h600, 0);
        applyStimulus(0, 1, 2'b00, 0, 0, 5'b11111);
        checkOutput("t4_terr_sticky", bus_if.timeout_err, 1);

        // rdy low during the broadcast cycle holds the pulse.
        applyStimulus(0, 1, 2'b01, 32'h700, 0, 0);
        checkOutput("t5_flush_0", bus_if.flush_out, 5'b11111);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 2'b00, 0, 0, 5'b11111);
            checkOutput("t5_flush_held", bus_if.flush_out, 5'b11111);
        end
        applyStimulus(0, 1, 2'b00, 0, 0, 5'b11111);
        checkOutput("t5_flush_done", bus_if.flush_out, 0);
        checkOutput("t5_busy_end", bus_if.busy, 0);

        // Reset in WAIT_ACK abandons the flush.
        applyStimulus(0, 1, 2'b01, 32'h800, 0, 0);
        applyStimulus(0, 1, 2'b00, 0, 0, 0);
        applyStimulus(0, 1, 2'b00, 0, 0, 0);
        applyStimulus(1, 1, 2'b00, 0, 0, 0);
        checkOutput("t6_busy", bus_if.busy, 0);
        checkOutput("t6_flush", bus_if.flush_out, 0);
        checkOutput("t6_grant", bus_if.grant, 0);
        checkOutput("t6_pc", bus_if.redirect_pc, 0);
        checkOutput("t6_src", bus_if.flush_src, 0);
        checkOutput("t6_count", bus_if.flush_count, 0);
        checkOutput("t6_terr", bus_if.timeout_err, 0);
        applyStimulus(0, 1, 2'b10, 0, 32'h900, 0);
        checkOutput("t6_grant_after", bus_if.grant, 2'b10);
        checkOutput("t6_count_after", bus_if.flush_count, 1);
        applyStimulus(0, 1, 2'b00, 0, 0, 5'b11111);

        // Randomized traffic; every third 400-cycle window has sink 3 silent.
        for (int c = 0; c < 4000; c++) begin
            dead   = ((c / 400) % 3) == 2;
            req[1] = ($urandom_range(0, 3) == 0);
            req[0] = dead ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 9) == 0);
            ack    = NK'($urandom & $urandom);
            if (dead) ack[3] = 1'b0;
            applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, req,
                          $urandom, $urandom, ack);
        end

        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 2'b00, 0, 0, 5'b11111);
        @(negedge clk);
        checkOutput("flush_q_drained", flush_q.size(), 0);
        checkOutput("end_q_drained", end_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
